// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receive path with start-bit validation, stop-bit check and a one-entry holding register.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick_os,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, data_q, data_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q, busy_d;
  logic                   rx_s, deliver;
  assign rx_s = sync2_q;
  always_comb begin
    state_d = state_q;
    sync1_d = rx;
    sync2_d = sync1_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    deliver = 1'b0;
    if (baud_tick_os) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE:  if (!rx_s) begin
                 tick_d  = '0;
                 state_d = START;
               end
        START: if (tick_q == T_HALF) begin
                 tick_d  = '0;
                 bit_d   = '0;
                 state_d = rx_s ? IDLE : DATA;
               end
        DATA:  if (tick_q == T_LAST) begin
                 shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                 bit_d   = bit_q + 1'b1;
                 state_d = (bit_q == B_LAST) ? STOP : DATA;
               end
        STOP:  if (tick_q == T_LAST) begin
                 deliver = 1'b1;
                 state_d = rx_s ? IDLE : BRK;
               end
        default: state_d = rx_s ? IDLE : BRK;
      endcase
    end
    // A delivery that finds the holding register full and unaccepted is dropped
    ovr_d = deliver && valid_q && !rx_ready;
    if (deliver && (!valid_q || rx_ready)) begin
      data_d  = shift_q;
      ferr_d  = !rx_s;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = busy_q;
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive half of the UART link and the counterpart of the existing transmitter. It samples the asynchronous `rx` line with an oversampling tick from the baud generator and validates the start bit at mid-bit. It then recovers DATA_BITS data bits LSB-first, checks the stop bit, and presents each byte on a valid/ready handshake with a one-entry holding register. It sits between the pad-side `rx` pin and the host-side consumer (CPU bus bridge or FIFO).

## Interface
- OVERSAMPLE, 16: oversample ticks per bit period; even, ≥ 4.
- DATA_BITS, 8: data bits per frame, 5–9.
- clk  input  1: system clock.
- reset_n  input  1: asynchronous, active-low reset.
- baud_tick_os  input  1: one-`clk` pulse at OVERSAMPLE × baud rate.
- rx  input  1: serial line, asynchronous to `clk`, idle high.
- rx_data  output  DATA_BITS: received byte; meaningful while `rx_valid`=1.
- rx_valid  output  1: byte available in the holding register.
- rx_ready  input  1: consumer accepts the byte when `rx_valid`=1 and `rx_ready`=1 on a `clk` edge.
- frame_err  output  1: stop bit sampled as 0 for the held byte; qualified by `rx_valid`.
- overrun  output  1: one-cycle pulse when a completed byte is dropped.
- rx_busy  output  1: frame reception in progress.

## Operation
- **Synchronizer**
  - `rx` passes through a 2-flop synchronizer (both flops reset to 1).
  - All decisions use the synchronized value `rx_s`.
- **Counters**
  - Tick counter: $clog2(OVERSAMPLE) bits.
  - Bit counter: wide enough for DATA_BITS.
  - Both advance only on `baud_tick_os`.
- **FSM states**
  - IDLE: on a tick with `rx_s`=0, clear the tick counter and go to START.
  - START: on the OVERSAMPLE/2-th tick after the detection tick, test `rx_s`.
    - `rx_s`=0: clear both counters, go to DATA.
    - `rx_s`=1: glitch; go to IDLE with no output.
  - DATA: every OVERSAMPLE ticks, shift `rx_s` in at the MSB of the shift register (right shift, LSB-first) and increment the bit counter. After the DATA_BITS-th sample, go to STOP.
  - STOP: OVERSAMPLE ticks later, sample the stop bit and deliver the byte (see Output handshake).
    - `rx_s`=1: go to IDLE.
    - `rx_s`=0: go to BREAK.
  - BREAK: wait for a tick with `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one frame_err byte, not a stream.
- **rx_busy**: 1 in START, DATA, STOP and BREAK; 0 in IDLE.
- **Output handshake**
  - Delivery loads `rx_data` and `frame_err`, and sets `rx_valid`.
  - `rx_valid` stays 1 until accepted.
  - On acceptance with no simultaneous delivery, `rx_valid` clears the next edge.
- **Simultaneous acceptance and delivery**: the new byte loads, `rx_valid` stays 1, and `overrun` stays 0.
- **Overrun**: a delivery while `rx_valid`=1 and `rx_ready`=0 drops the new byte.
  - The holding register keeps the old byte and its `frame_err`.
  - `overrun` pulses for one cycle.
- **Reset mid-operation**: asserting `reset_n` at any time returns the FSM to IDLE and clears counters, the shift register and all outputs. No partial byte is delivered.

## Timing
- **Reset values**: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0, synchronizer=1, state IDLE.
- **Input latency**: 2 `clk` from a change on `rx` to `rx_s`. Start detection happens on the first tick after that.
- **Sample points**, counted from the detection tick T0:
  - Start bit: T0 + OVERSAMPLE/2 ticks.
  - Data bit k (k = 0..DATA_BITS-1): T0 + OVERSAMPLE/2 + (k+1)·OVERSAMPLE ticks.
  - Stop bit: T0 + OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks.
- **Delivery**: `rx_valid`, `rx_data` and `frame_err` update on the `clk` edge that registers the stop-bit sample tick. They are visible the cycle after that tick.
- **Next frame**: after a good stop bit, IDLE is reached at the stop sample point. A start edge half a bit later is detected, so a transmitter with zero inter-frame gap is supported.
- **Tick counter**: wraps modulo OVERSAMPLE. Ticks arriving in back-to-back `clk` cycles are each counted.
- **Throughput**: the consumer may hold `rx_ready`=1 permanently. Each byte is then accepted one cycle after `rx_valid` rises.

## Test plan
- Frame 0xA5 at OVERSAMPLE=16, `rx_ready`=1 → `rx_valid` pulses for 1 cycle with `rx_data`=0xA5, `frame_err`=0, and `rx_busy` drops at the stop sample.
- `rx` low for 4 ticks, then high → no `rx_valid`, FSM back in IDLE; a following frame 0x3C is received as 0x3C.
- Frame 0x3C with stop bit 0, then line held low 3 bit times → one byte 0x3C with `frame_err`=1, `rx_busy`=1 until `rx` returns high, no further bytes.
- Frames 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses once at the 0x22 stop sample.
  - Repeat with `rx_ready`=1 only in that cycle → 0x22 is presented and `overrun` stays 0.
- `reset_n` pulsed low during data bit 3 of frame 0xFF → all outputs 0 immediately; next frame 0x5A is received as 0x5A with `frame_err`=0.
- Loopback with the existing transmitter (same baud generator): 256 bytes 0x00–0xFF back-to-back → all received in order, no `frame_err`, no `overrun`.
